ones_frame_acc: RTL and testbench
=================================

Name: ones_frame_acc

Overview:
- Downstream consumer of the 8-bit ones-count stage: accepts one 4-bit per-word count per valid/ready transfer.
- Accumulates counts over a frame of FRAME_LEN words, then presents frame total, frame maximum and an input-error flag to a downstream sink.
- Output side uses a valid/ready handshake.
- Input is back-pressured while a finished frame result waits to be taken.

Parameters:
- DAT_W, 8: width of the word the upstream counter examines; a legal count is 0..DAT_W.
- CNT_W, 4: width of count_in and frame_max.
- FRAME_LEN, 16: words per frame, minimum 2.
- SUM_W, 8: width of frame_sum.
- IDX_W, 4: width of the word index; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  count_in holds a valid count.
- in_ready  out  1  block accepts count_in this cycle.
- count_in  in  CNT_W  ones count of one upstream word.
- out_valid  out  1  frame result valid.
- out_ready  in  1  sink takes the result this cycle.
- frame_sum  out  SUM_W  sum of the counts in the frame.
- frame_max  out  CNT_W  largest count in the frame.
- frame_err  out  1  at least one count_in > DAT_W occurred in the frame.
- word_idx  out  IDX_W  number of words accepted so far in the current frame.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - state=ACCUM, in_ready=1, out_valid=0;
  - frame_sum=0, frame_max=0, frame_err=0, word_idx=0;
  - internal accumulators cleared;
  - any partial frame or pending result is discarded.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - A transfer occurs when in_valid && in_ready at the edge. On each transfer:
    - acc_sum += count_in, widened to SUM_W with unsigned arithmetic; wraps modulo 2^SUM_W unless the optional feature is enabled;
    - acc_max = max(acc_max, count_in), unsigned compare;
    - acc_err |= (count_in > DAT_W); the out-of-range value is still summed and compared unchanged;
    - word_idx += 1.
  - If the transfer is word FRAME_LEN-1 (word_idx == FRAME_LEN-1 before the edge):
    - frame_sum, frame_max and frame_err are loaded with the updated accumulator values, including this word;
    - accumulators and word_idx clear to 0;
    - state moves to HOLD, and out_valid=1 from the next cycle. Latency from the last input transfer to out_valid is 1 cycle.
  - in_valid=0 leaves all state unchanged. Gaps are allowed anywhere in a frame.
- State HOLD:
  - in_ready=0, out_valid=1.
  - frame_sum, frame_max, frame_err stay stable until the result is taken.
  - On out_ready=1 at an edge: the result is taken; next cycle state=ACCUM with in_ready=1 and out_valid=0.
  - frame_* outputs keep their last values after the result is taken; they are only meaningful while out_valid=1.
  - in_valid asserted during HOLD is ignored; upstream must hold its data.
- in_ready is a pure function of state (registered), with no combinational path from out_ready.
- Maximum throughput: FRAME_LEN words per FRAME_LEN+1 cycles when out_ready is tied to 1.
- frame_max ties: equal counts leave the max unchanged. A frame of all zeros gives frame_max=0.

Optional Feature:
- Macro: ONES_FRAME_ACC_SAT_EN.
- Defined:
  - acc_sum saturates at 2^SUM_W-1 and never wraps;
  - an extra output port frame_sat (1 bit) is added; it is set in the result if saturation occurred in that frame, reset 0, and has the same timing as frame_err.
- Undefined:
  - acc_sum wraps modulo 2^SUM_W;
  - the frame_sat port does not exist.

Test Plan:
- Reset, then 16 transfers of count_in=1 back-to-back with out_ready=1 -> out_valid rises 1 cycle after the 16th transfer; frame_sum=16, frame_max=1, frame_err=0; in_ready=0 for exactly 1 cycle.
- Counts 0,1,2,...,8, then 0 for the remaining 7 words -> frame_sum=36, frame_max=8, frame_err=0.
- Frame complete with out_ready=0 for 5 cycles, in_valid=1 held throughout -> outputs stable, in_ready=0, no word accepted; after out_ready=1, the next frame starts with word_idx=0.
- count_in=9 on word 3, all others 0 -> frame_err=1, frame_max=9, frame_sum=9; the following frame of all 0 gives frame_err=0.
- rst pulsed after 10 accepted words -> word_idx=0 and out_valid=0; the next 16 words of count 2 give frame_sum=32.
- SUM_W=5 with 16 words of count 8 -> with ONES_FRAME_ACC_SAT_EN: frame_sum=31, frame_sat=1; without it: frame_sum=128 mod 32=0.

Source files
------------

// File: rtl/ones_frame_acc.sv
// Frame accumulator for per-word ones counts: sums, tracks the maximum and flags
// out-of-range counts over FRAME_LEN words. Optional macro ONES_FRAME_ACC_SAT_EN saturates the sum.
module ones_frame_acc #(
  parameter int unsigned DAT_W     = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned SUM_W     = 8,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] count_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] frame_sum,
  output logic [CNT_W-1:0] frame_max,
  output logic             frame_err,
`ifdef ONES_FRAME_ACC_SAT_EN
  output logic             frame_sat,
`endif
  output logic [IDX_W-1:0] word_idx
);

  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [CNT_W-1:0] DAT_MAX  = CNT_W'(DAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0] acc_max_q, acc_max_d;
  logic             acc_err_q, acc_err_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;
  logic [CNT_W-1:0] frame_max_q, frame_max_d;
  logic             frame_err_q, frame_err_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;

  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] max_nxt;
  logic             err_nxt;

`ifdef ONES_FRAME_ACC_SAT_EN
  logic             acc_sat_q, acc_sat_d;
  logic             frame_sat_q, frame_sat_d;
  logic             sat_nxt;
  logic [SUM_W:0]   sum_ext;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    acc_err_d   = acc_err_q;
    frame_sum_d = frame_sum_q;
    frame_max_d = frame_max_q;
    frame_err_d = frame_err_q;
    word_idx_d  = word_idx_q;

`ifdef ONES_FRAME_ACC_SAT_EN
    acc_sat_d   = acc_sat_q;
    frame_sat_d = frame_sat_q;
    // One extra carry bit detects overflow; the sum then pins at all-ones.
    sum_ext     = {1'b0, acc_sum_q} + (SUM_W + 1)'(count_in);
    if (sum_ext[SUM_W]) begin
      sum_nxt = '1;
      sat_nxt = 1'b1;
    end else begin
      sum_nxt = sum_ext[SUM_W-1:0];
      sat_nxt = acc_sat_q;
    end
`else
    sum_nxt     = acc_sum_q + SUM_W'(count_in);
`endif
    max_nxt = (count_in > acc_max_q) ? count_in : acc_max_q;
    err_nxt = acc_err_q | (count_in > DAT_MAX);

    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          if (word_idx_q == LAST_IDX) begin
            frame_sum_d = sum_nxt;
            frame_max_d = max_nxt;
            frame_err_d = err_nxt;
            acc_sum_d   = '0;
            acc_max_d   = '0;
            acc_err_d   = 1'b0;
            word_idx_d  = '0;
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
`ifdef ONES_FRAME_ACC_SAT_EN
            frame_sat_d = sat_nxt;
            acc_sat_d   = 1'b0;
`endif
          end else begin
            acc_sum_d  = sum_nxt;
            acc_max_d  = max_nxt;
            acc_err_d  = err_nxt;
            word_idx_d = word_idx_q + 1'b1;
`ifdef ONES_FRAME_ACC_SAT_EN
            acc_sat_d  = sat_nxt;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_err_q   <= 1'b0;
      frame_sum_q <= '0;
      frame_max_q <= '0;
      frame_err_q <= 1'b0;
      word_idx_q  <= '0;
`ifdef ONES_FRAME_ACC_SAT_EN
      acc_sat_q   <= 1'b0;
      frame_sat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_err_q   <= acc_err_d;
      frame_sum_q <= frame_sum_d;
      frame_max_q <= frame_max_d;
      frame_err_q <= frame_err_d;
      word_idx_q  <= word_idx_d;
`ifdef ONES_FRAME_ACC_SAT_EN
      acc_sat_q   <= acc_sat_d;
      frame_sat_q <= frame_sat_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign frame_sum = frame_sum_q;
  assign frame_max = frame_max_q;
  assign frame_err = frame_err_q;
  assign word_idx  = word_idx_q;
`ifdef ONES_FRAME_ACC_SAT_EN
  assign frame_sat = frame_sat_q;
`endif

endmodule

// File: tb/tb_ones_frame_acc.sv
// Scoreboard bench for ones_frame_acc: a default instance and a SUM_W=5 instance
// share all stimulus; expected frame results are queued as words are accepted.
module tb_ones_frame_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] count_in = '0;

  logic       in_ready, out_valid, frame_err;
  logic [7:0] frame_sum;
  logic [3:0] frame_max, word_idx;
  logic       in_ready5, out_valid5, frame_err5;
  logic [4:0] frame_sum5;
  logic [3:0] frame_max5, word_idx5;
`ifdef ONES_FRAME_ACC_SAT_EN
  logic       frame_sat, frame_sat5;
`endif

  ones_frame_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .count_in(count_in), .out_valid(out_valid), .out_ready(out_ready),
    .frame_sum(frame_sum), .frame_max(frame_max), .frame_err(frame_err),
`ifdef ONES_FRAME_ACC_SAT_EN
    .frame_sat(frame_sat),
`endif
    .word_idx(word_idx)
  );

  ones_frame_acc #(.SUM_W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .count_in(count_in), .out_valid(out_valid5), .out_ready(out_ready),
    .frame_sum(frame_sum5), .frame_max(frame_max5), .frame_err(frame_err5),
`ifdef ONES_FRAME_ACC_SAT_EN
    .frame_sat(frame_sat5),
`endif
    .word_idx(word_idx5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic [3:0] max;
    logic       err;
    logic       sat;
    logic [4:0] sum5;
    logic       sat5;
  } exp_t;

  exp_t q[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         m_idx = 0;
  bit         m_hold = 1'b0;
  logic [7:0] m_sum = '0;
  logic [3:0] m_max = '0;
  logic       m_err = 1'b0;
  logic       m_sat = 1'b0;
  logic [4:0] m_sum5 = '0;
  logic       m_sat5 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    m_idx = 0; m_sum = '0; m_max = '0; m_err = 1'b0;
    m_sat = 1'b0; m_sum5 = '0; m_sat5 = 1'b0;
  endtask

  // Runs just before the rising edge with the inputs the DUT is about to sample.
  task automatic monitor();
    exp_t       e;
    logic [8:0] s9;
    logic [5:0] s6;
    bit         was_hold;
    if (rst) begin
      clear_acc();
      q.delete();
      m_hold = 1'b0;
      return;
    end
    was_hold = m_hold;
    check("in_ready", {31'b0, in_ready}, {31'b0, !was_hold});
    check("out_valid", {31'b0, out_valid}, {31'b0, was_hold});
    check("word_idx", {28'b0, word_idx}, m_idx);
    check("out_valid5", {31'b0, out_valid5}, {31'b0, was_hold});
    check("word_idx5", {28'b0, word_idx5}, m_idx);
    if (was_hold) begin
      check("result_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        check("frame_sum", {24'b0, frame_sum}, {24'b0, q[0].sum});
        check("frame_max", {28'b0, frame_max}, {28'b0, q[0].max});
        check("frame_err", {31'b0, frame_err}, {31'b0, q[0].err});
        check("frame_sum5", {27'b0, frame_sum5}, {27'b0, q[0].sum5});
        check("frame_err5", {31'b0, frame_err5}, {31'b0, q[0].err});
`ifdef ONES_FRAME_ACC_SAT_EN
        check("frame_sat", {31'b0, frame_sat}, {31'b0, q[0].sat});
        check("frame_sat5", {31'b0, frame_sat5}, {31'b0, q[0].sat5});
`endif
        if (out_ready) begin
          void'(q.pop_front());
          m_hold = 1'b0;
        end
      end
    end else if (in_valid) begin
      s9 = {1'b0, m_sum} + {5'b0, count_in};
      s6 = {1'b0, m_sum5} + {2'b0, count_in};
`ifdef ONES_FRAME_ACC_SAT_EN
      m_sum  = s9[8] ? 8'hFF : s9[7:0];
      m_sum5 = s6[5] ? 5'h1F : s6[4:0];
      m_sat  = m_sat | s9[8];
      m_sat5 = m_sat5 | s6[5];
`else
      m_sum  = s9[7:0];
      m_sum5 = s6[4:0];
`endif
      if (count_in > m_max) m_max = count_in;
      if (count_in > 4'd8) m_err = 1'b1;
      m_idx++;
      if (m_idx == 16) begin
        e.sum = m_sum; e.max = m_max; e.err = m_err; e.sat = m_sat;
        e.sum5 = m_sum5; e.sat5 = m_sat5;
        q.push_back(e);
        clear_acc();
        m_hold = 1'b1;
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge and returns at the next falling edge.
  task automatic step(input logic v, input logic [3:0] c, input logic r);
    in_valid  = v;
    count_in  = c;
    out_ready = r;
    #4;
    monitor();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    check("rst_frame_sum", {24'b0, frame_sum}, 0);
    check("rst_frame_max", {28'b0, frame_max}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_word_idx", {28'b0, word_idx}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);

    // All ones, back-to-back: sum 16, max 1.
    repeat (16) step(1'b1, 4'd1, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);

    // Ramp 0..8 then zeros: sum 36, max 8.
    for (int i = 0; i <= 8; i++) step(1'b1, 4'(i), 1'b1);
    repeat (7) step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);

    // Sink stalls 5 cycles while upstream keeps in_valid high.
    repeat (16) step(1'b1, 4'd3, 1'b0);
    repeat (5) step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd5, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    check("idx_after_stall", {28'b0, word_idx}, 0);

    // Out-of-range count on word 3, then a clean all-zero frame.
    for (int i = 0; i < 16; i++) step(1'b1, (i == 3) ? 4'd9 : 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    repeat (16) step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);

    // Reset mid-frame, then a frame of 2s with gaps: sum 32.
    repeat (10) step(1'b1, 4'd7, 1'b1);
    rst = 1'b1;
    step(1'b0, 4'd0, 1'b1);
    rst = 1'b0;
    check("idx_after_rst", {28'b0, word_idx}, 0);
    check("valid_after_rst", {31'b0, out_valid}, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'd2, 1'b1);
      if (i == 5) repeat (3) step(1'b0, 4'd0, 1'b1);
    end
    step(1'b0, 4'd0, 1'b1);

    // Sixteen 8s: 128 on the default instance, wrap or saturate on SUM_W=5.
    repeat (16) step(1'b1, 4'd8, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    check("all_results_taken", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
